// File: rtl/axi_slave_aw_ctrl_pkg.sv
// Shared AXI write-address types and constants for the slave AW/W stages.
package axi_slave_aw_ctrl_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_DATA_WIDTH = 128;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [15:0]             addr;
        logic [3:0]              len;
    } aw_entry_t;

    // Byte offset within the 4 KB page plus burst length must not pass 4096.
    function automatic logic crosses_4k(input logic [11:0] offs, input logic [3:0] len,
                                        input int unsigned beat_bytes);
        logic [13:0] end_byte;
        end_byte = {2'b00, offs} + 14'((32'(len) + 32'd1) * beat_bytes);
        return end_byte > 14'd4096;
    endfunction

endpackage

// File: rtl/axi_aw_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head reads as zero when empty.
module axi_aw_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_slave_aw_ctrl.sv
// AXI slave AW front end: handshake, buffering for the W stage, and a sticky
// check against the supported subset (INCR, full-width beats, no 4 KB crossing).
module axi_slave_aw_ctrl
    import axi_slave_aw_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          awvalid_i,
    output logic                          awready_o,
    input  logic [ID_WIDTH-1:0]           awid_i,
    input  logic [ADDR_WIDTH-1:0]         awaddr_i,
    input  logic [3:0]                    awlen_i,
    input  logic [2:0]                    awsize_i,
    input  logic [1:0]                    awburst_i,
    output logic [ID_WIDTH-1:0]           awid_o,
    output logic [ADDR_WIDTH-1:0]         awaddr_o,
    output logic [3:0]                    awlen_o,
    output logic                          empty_o,
    input  logic                          rden_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          proto_err_o
);

    localparam int          ENTRY_W    = ID_WIDTH + ADDR_WIDTH + 4;
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int          BEAT_LOG2  = $clog2(BEAT_BYTES);

    logic               full;
    logic               push;
    logic               violation;
    logic [ENTRY_W-1:0] head;

    assign awready_o = !rst && !full;
    assign push      = awvalid_i && awready_o;

    assign violation = (awburst_i != BURST_INCR)
                    || (awsize_i != 3'(BEAT_LOG2))
                    || crosses_4k(awaddr_i[11:0], awlen_i, BEAT_BYTES);

    axi_aw_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   ({awid_i, awaddr_i, awlen_i}),
        .rd_en (rden_i),
        .dout  (head),
        .empty (empty_o),
        .full  (full),
        .count (count_o)
    );

    assign {awid_o, awaddr_o, awlen_o} = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_o <= 1'b0;
        end else if (push && violation) begin
            proto_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_slave_aw_ctrl.sv
// Directed and randomized bench for axi_slave_aw_ctrl against a queue-based reference model.
module tb_axi_slave_aw_ctrl;

    localparam int BYTES   = 16;
    localparam int SIZE_OK = 4;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [3:0]  awid_i = '0;
    logic [15:0] awaddr_i = '0;
    logic [3:0]  awlen_i = '0;
    logic [2:0]  awsize_i = 3'(SIZE_OK);
    logic [1:0]  awburst_i = 2'b01;
    logic [3:0]  awid_o;
    logic [15:0] awaddr_o;
    logic [3:0]  awlen_o;
    logic        empty_o;
    logic        rden_i = 1'b0;
    logic [2:0]  count_o;
    logic        proto_err_o;

    axi_slave_aw_ctrl #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (128),
        .ID_WIDTH   (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .awvalid_i   (awvalid_i),
        .awready_o   (awready_o),
        .awid_i      (awid_i),
        .awaddr_i    (awaddr_i),
        .awlen_i     (awlen_i),
        .awsize_i    (awsize_i),
        .awburst_i   (awburst_i),
        .awid_o      (awid_o),
        .awaddr_o    (awaddr_o),
        .awlen_o     (awlen_o),
        .empty_o     (empty_o),
        .rden_i      (rden_i),
        .count_o     (count_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int addr;
        int len;
    } entry_t;

    entry_t q[$];
    bit     m_err;
    bit     last_acc;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model decides from pre-edge state, then DUT outputs are checked after the edge.
    task automatic cycle();
        bit acc;
        bit pop;
        bit bad;
        entry_t e;
        acc = awvalid_i && !rst && (q.size() < DEPTH);
        pop = rden_i && (q.size() > 0);
        bad = (awburst_i != 2'b01) || (int'(awsize_i) != SIZE_OK)
           || ((int'(awaddr_i) % 4096) + (int'(awlen_i) + 1) * BYTES > 4096);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 0;
            acc = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.id = int'(awid_i); e.addr = int'(awaddr_i); e.len = int'(awlen_i);
                q.push_back(e);
                if (bad) m_err = 1;
            end
        end
        last_acc = acc;
        #1;
        chk("awready", 32'(awready_o), 32'(!rst && q.size() < DEPTH));
        chk("empty",   32'(empty_o),   32'(q.size() == 0));
        chk("count",   32'(count_o),   32'(q.size()));
        chk("awid",    32'(awid_o),    q.size() > 0 ? 32'(q[0].id)   : 32'd0);
        chk("awaddr",  32'(awaddr_o),  q.size() > 0 ? 32'(q[0].addr) : 32'd0);
        chk("awlen",   32'(awlen_o),   q.size() > 0 ? 32'(q[0].len)  : 32'd0);
        chk("proto_err", 32'(proto_err_o), 32'(m_err));
    endtask

    task automatic set_aw(input bit v, input int id, input int addr, input int len,
                          input int size, input int burst);
        awvalid_i = v;
        awid_i    = 4'(id);
        awaddr_i  = 16'(addr);
        awlen_i   = 4'(len);
        awsize_i  = 3'(size);
        awburst_i = 2'(burst);
    endtask

    initial begin
        bit pending;
        m_err = 0;
        last_acc = 0;
        // Reset and idle, including a pop while empty.
        #1;
        cycle(); cycle();
        rst = 0;
        cycle();
        rden_i = 1; cycle(); rden_i = 0;
        chk("idle_ready", 32'(awready_o), 32'd1);

        // Single push then pop.
        set_aw(1, 3, 'h0100, 3, SIZE_OK, 1); cycle();
        chk("single_addr", 32'(awaddr_o), 32'h0100);
        awvalid_i = 0; rden_i = 1; cycle(); rden_i = 0;
        chk("single_empty", 32'(empty_o), 32'd1);

        // Fill to full; fifth request held through a full-cycle pop.
        for (int i = 0; i < 4; i++) begin
            set_aw(1, i, i * 'h100, i, SIZE_OK, 1); cycle();
        end
        chk("full_ready", 32'(awready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        set_aw(1, 4, 'h0400, 4, SIZE_OK, 1);
        cycle(); cycle();
        rden_i = 1; cycle(); rden_i = 0;
        chk("held_not_taken", 32'(last_acc), 32'd0);
        chk("after_pop_head", 32'(awid_o), 32'd1);
        cycle();
        chk("held_taken", 32'(last_acc), 32'd1);
        awvalid_i = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", 32'(awid_o), 32'(i));
            rden_i = 1; cycle();
        end
        rden_i = 0;

        // Concurrent push/pop at count 2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            set_aw(1, 8 + i, 'h200 + i * 16, 0, SIZE_OK, 1); cycle();
        end
        rden_i = 1;
        for (int i = 0; i < 8; i++) begin
            set_aw(1, i, 'h300 + i * 16, 1, SIZE_OK, 1); cycle();
            chk("steady_count", 32'(count_o), 32'd2);
        end
        awvalid_i = 0;
        cycle(); cycle(); rden_i = 0;

        // Protocol errors.
        set_aw(1, 5, 'h0000, 0, SIZE_OK, 2); cycle(); awvalid_i = 0;
        chk("wrap_err", 32'(proto_err_o), 32'd1);
        chk("wrap_queued", 32'(count_o), 32'd1);
        rst = 1; cycle(); rst = 0;
        set_aw(1, 6, 'h0FF0, 3, SIZE_OK, 1); cycle(); awvalid_i = 0;
        chk("cross_err", 32'(proto_err_o), 32'd1);
        rst = 1; cycle(); rst = 0;
        set_aw(1, 7, 'h0FC0, 3, SIZE_OK, 1); cycle(); awvalid_i = 0;
        chk("edge_4k_ok", 32'(proto_err_o), 32'd0);
        set_aw(1, 7, 'h1000, 0, 2, 1); cycle(); awvalid_i = 0;
        chk("size_err", 32'(proto_err_o), 32'd1);

        // Reset with three entries buffered.
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            set_aw(1, i + 1, 'h500 + i * 16, 2, SIZE_OK, 1); cycle();
        end
        awvalid_i = 0;
        chk("pre_reset_count", 32'(count_o), 32'd3);
        rst = 1; cycle(); rst = 0;
        cycle();
        rden_i = 1; cycle(); rden_i = 0;
        chk("post_reset_empty", 32'(empty_o), 32'd1);

        // Randomized traffic; master keeps a request stable until accepted.
        pending = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pending && ($urandom_range(0, 99) < 60)) begin
                set_aw(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 15)),
                       ($urandom_range(0, 99) < 92) ? SIZE_OK : int'($urandom_range(0, 7)),
                       ($urandom_range(0, 99) < 90) ? 1 : int'($urandom_range(0, 3)));
                pending = 1;
            end
            rden_i = ($urandom_range(0, 99) < 50);
            rst = ($urandom_range(0, 99) < 3);
            cycle();
            if (last_acc || rst) begin
                pending = 0;
                awvalid_i = 0;
            end
        end
        rst = 0; rden_i = 0; awvalid_i = 0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
